stopwatch_display: RTL

Consumer end of the stopwatch time bus. Takes the binary minutes/seconds values (0-59 each) and drives a 4-digit multiplexed, active-low seven-segment display. Scans the digits, splits each field into BCD digits, and latches one coherent snapshot per scan frame. In adjust mode the selected field blinks. Sits between the stopwatch counter and the board display pins.

---
 rtl/stopwatch_pkg.sv | 32 +++
 rtl/seg7_bcd_decode.sv | 38 +++
 rtl/stopwatch_display.sv | 137 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared constants for the stopwatch display path: active-low
//               segment patterns, digit slot encoding and field range limit.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    localparam logic [5:0] MAX_FIELD = 6'd59;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/seg7_bcd_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_bcd_decode
// Description : BCD digit to active-low seven-segment pattern, with a dash
//               override for out-of-range fields.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_bcd_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule : seg7_bcd_decode
`default_nettype wire

// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_display
// Description : 4-digit multiplexed MM.SS display driver with per-frame
//               snapshot and adjust-mode blink. Optional leading-zero blanking
//               of the minutes tens digit via STOPWATCH_DISP_LZ_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 250,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       sel,
    input  logic       adj,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int c_scan_div  = CLK_HZ / (4 * SCAN_HZ);
    localparam int c_blink_div = CLK_HZ / (2 * BLINK_HZ);
    localparam int c_scan_w    = $clog2(c_scan_div);
    localparam int c_blink_w   = $clog2(c_blink_div);
    localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(c_scan_div - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(c_blink_div - 1);

    logic [c_scan_w-1:0]  r_scan_cnt;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_ph;
    logic [1:0]           r_idx;
    logic [5:0]           r_snap_min;
    logic [5:0]           r_snap_sec;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_dp;

    logic       w_tick;
    logic [5:0] w_min;
    logic [5:0] w_sec;
    logic       w_is_min;
    logic [5:0] w_field;
    logic       w_dash;
    logic [3:0] w_tens;
    logic [3:0] w_ones;
    logic [3:0] w_digit;
    logic [6:0] w_seg_dec;
    logic       w_blink;
    logic       w_lz;
    logic       w_blank;
    logic [3:0] w_an_next;
    logic [6:0] w_seg_next;
    logic       w_dp_next;

    assign w_tick = (r_scan_cnt == c_scan_last);

    // Slot 0 opens a frame and must show the value being latched right now
    assign w_min    = (r_idx == DIG_SEC_ONES) ? minutes : r_snap_min;
    assign w_sec    = (r_idx == DIG_SEC_ONES) ? seconds : r_snap_sec;
    assign w_is_min = r_idx[1];
    assign w_field  = w_is_min ? w_min : w_sec;
    assign w_dash   = (w_field > MAX_FIELD);
    assign w_tens   = 4'(w_field / 6'd10);
    assign w_ones   = 4'(w_field % 6'd10);
    assign w_digit  = r_idx[0] ? w_tens : w_ones;

    seg7_bcd_decode u_dec (
        .digit (w_digit),
        .dash  (w_dash),
        .seg   (w_seg_dec)
    );

    // sel=1 selects seconds (slots 0/1), sel=0 selects minutes (slots 2/3)
    assign w_blink = adj & r_blink_ph & (sel != w_is_min);

`ifdef STOPWATCH_DISP_LZ_BLANK_EN
    assign w_lz = (r_idx == DIG_MIN_TENS) && !w_dash && (w_tens == 4'd0);
`else
    assign w_lz = 1'b0;
`endif

    assign w_blank    = w_blink | w_lz;
    assign w_an_next  = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
    assign w_seg_next = w_blank ? SEG_BLANK : w_seg_dec;
    assign w_dp_next  = (r_idx != DIG_MIN_ONES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= DIG_SEC_ONES;
            r_snap_min <= '0;
            r_snap_sec <= '0;
            r_an       <= 4'b1111;
            r_seg      <= SEG_BLANK;
            r_dp       <= 1'b1;
        end else begin
            r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
            if (w_tick) begin
                if (r_idx == DIG_SEC_ONES) begin
                    r_snap_min <= minutes;
                    r_snap_sec <= seconds;
                end
                r_an  <= w_an_next;
                r_seg <= w_seg_next;
                r_dp  <= w_dp_next;
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (!adj) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule : stopwatch_display
`default_nettype wire
